drv_pwr_seq: RTL
================

Name: drv_pwr_seq

Overview:
- Staggered power-on sequencer for the 24 drive bays on the baseboard.
- Drives DRV_PWREN one bay at a time to bound inrush current, then waits for that bay's DRV_PWROK before starting the next bay.
- Its DRV_PWROK inputs are the same signals consumed by the per-bay PCIe reset release logic, so this block gates when each bay's 100 ms PERST timer starts.
- Flags bays that time out or lose power-good, and handles hot-plug insert/remove.

Parameters:
- NUM_DRV, 24, number of drive bays (index 0..NUM_DRV-1).
- STAGGER_CYC, 2500000, idle gap in SYSCLK cycles after each bay resolves (OK or fault) before the next enable.
- PWROK_TIMEOUT_CYC, 12500000, cycles allowed from PWREN assertion to PWROK high.
- TMR_W, 24, timer width; must hold max(STAGGER_CYC, PWROK_TIMEOUT_CYC).

Ports:
- SYSCLK, input, 1, system clock.
- RESET, input, 1, asynchronous active-high reset.
- PWR_REQ, input, 1, level; 1 = power all present bays, 0 = power all bays down.
- DRV_PRSNT, input, NUM_DRV, bay presence, 1 = drive installed (pre-synchronised).
- DRV_PWROK, input, NUM_DRV, per-bay power-good (pre-synchronised).
- DRV_PWREN, output, NUM_DRV, per-bay power enable, registered.
- DRV_FAULT, output, NUM_DRV, sticky per-bay fault, registered.
- SEQ_BUSY, output, 1, high in WAIT_OK or GAP.
- SEQ_DONE, output, 1, high when PWR_REQ=1 and no eligible bay remains.
- CUR_IDX, output, 5, index of the bay being sequenced; valid while SEQ_BUSY.

Behaviour:
- Reset (async, RESET=1):
  - DRV_PWREN=0, DRV_FAULT=0, SEQ_BUSY=0, SEQ_DONE=0, CUR_IDX=0, timer=0, state=IDLE.
  - Reset mid-sequence drops all enables immediately.
- Eligible bay: PRSNT=1, PWREN=0 and FAULT=0. The lowest eligible index wins (fixed priority).
- States:
  - IDLE: if PWR_REQ=1, go to SCAN.
  - SCAN (1 cycle):
    - If an eligible bay exists: set PWREN[idx]=1, CUR_IDX=idx, timer=0, go to WAIT_OK.
    - Otherwise stay in SCAN with SEQ_DONE=1; re-evaluate every cycle so a newly inserted bay is picked up.
  - WAIT_OK:
    - Timer increments each cycle.
    - If PWROK[idx]=1: timer=0, go to GAP.
    - Else if timer==PWROK_TIMEOUT_CYC-1: FAULT[idx]=1, PWREN[idx]=0, timer=0, go to GAP.
    - PWROK and timeout in the same cycle: PWROK wins.
  - GAP: timer increments; at timer==STAGGER_CYC-1, timer=0 and go to SCAN.
- Latency:
  - PWR_REQ rise to first PWREN = 2 cycles (IDLE→SCAN, SCAN→WAIT_OK with PWREN registered).
  - Minimum spacing between consecutive enables when PWROK is immediate = 1 (detect) + STAGGER_CYC + 1 (SCAN) cycles.
- PWR_REQ=0 in any state:
  - Next cycle all PWREN=0, state=IDLE, timer=0, SEQ_BUSY=0, SEQ_DONE=0.
  - FAULT is retained.
  - A PWR_REQ fall-then-rise re-sequences from bay 0; faulted bays stay skipped.
- Removal (PRSNT[i] falls):
  - Next cycle PWREN[i]=0 and FAULT[i]=0.
  - If i==CUR_IDX in WAIT_OK: no fault is recorded and the FSM goes to GAP.
- Power-good loss: PWREN[i]=1 and PWROK[i]=0 outside WAIT_OK for that bay gives FAULT[i]=1 and PWREN[i]=0 next cycle. No auto-retry.
- Fault clear: only by reset, removal, or reinsertion. A faulted bay is never re-enabled while FAULT=1.
- Simultaneous events:
  - Removal of CUR_IDX takes priority over PWROK/timeout.
  - PWR_REQ=0 takes priority over everything except reset.
- Counter rules: timer is unsigned TMR_W bits; it compares for equality only and never wraps because it is cleared on every state exit.
- Constraints: NUM_DRV<=32; STAGGER_CYC>=1 and PWROK_TIMEOUT_CYC>=1 (elaboration check).

Test Plan (STAGGER_CYC=4, PWROK_TIMEOUT_CYC=8, PWROK model returns 3 cycles after PWREN):
- Reset and PWR_REQ: all 24 bays present, PWR_REQ=1 at cycle 0.
  - PWREN[0] rises at cycle 2.
  - Bays enable strictly in order 0..23, one at a time, with each PWREN rise exactly 9 cycles after the previous one (3 for PWROK + 1 detect + 4 gap + 1 scan).
  - SEQ_DONE=1 after bay 23 resolves.
- Timeout: bay 5 PWROK held low.
  - At WAIT_OK timer=7: FAULT[5]=1 and PWREN[5]=0.
  - Bay 6 enables after the 4-cycle gap plus SCAN.
  - Bay 5 is never re-enabled.
- Sparse presence: only bays 3, 17 and 22 present → only those PWREN rise, in that order, then SEQ_DONE=1.
  - Inserting bay 10 while in SCAN/done → PWREN[10] rises 1 cycle after the PRSNT rise.
- Removal mid-wait: remove bay 8 (CUR_IDX=8) at WAIT_OK timer=2.
  - PWREN[8]=0, FAULT[8]=0, FSM goes to GAP; bay 9 sequences next.
- Power-good loss: drop PWROK[2] after bay 2 is up → FAULT[2]=1 and PWREN[2]=0 one cycle later; other bays are unaffected.
- Abort and reset:
  - PWR_REQ=0 while bay 12 is in WAIT_OK → all PWREN=0 next cycle, FAULT retained; PWR_REQ=1 restarts at bay 0.
  - Asserting RESET mid-GAP clears every output immediately, asynchronously.

Source files
------------

// File: rtl/drv_pwr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : drv_pwr_seq
//  Description : Staggered power-on sequencer for the drive bays. Enables one
//                bay at a time, waits for its power-good, then idles before
//                the next. Flags timeouts and power-good loss, and tracks
//                hot-plug insert/remove.
//  Revision    : 1.0 - initial release
// ============================================================================
module drv_pwr_seq #(
    parameter int unsigned NUM_DRV           = 24,
    parameter int unsigned STAGGER_CYC       = 2500000,
    parameter int unsigned PWROK_TIMEOUT_CYC = 12500000,
    parameter int unsigned TMR_W             = 24
) (
    input  logic               SYSCLK,
    input  logic               RESET,
    input  logic               PWR_REQ,
    input  logic [NUM_DRV-1:0] DRV_PRSNT,
    input  logic [NUM_DRV-1:0] DRV_PWROK,
    output logic [NUM_DRV-1:0] DRV_PWREN,
    output logic [NUM_DRV-1:0] DRV_FAULT,
    output logic               SEQ_BUSY,
    output logic               SEQ_DONE,
    output logic [4:0]         CUR_IDX
);

    // ------------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------------
    if ((NUM_DRV < 1) || (NUM_DRV > 32)) begin : g_chk_num_drv
        $error("drv_pwr_seq: NUM_DRV must be in 1..32");
    end
    if ((STAGGER_CYC < 1) || (PWROK_TIMEOUT_CYC < 1)) begin : g_chk_cycles
        $error("drv_pwr_seq: STAGGER_CYC and PWROK_TIMEOUT_CYC must be >= 1");
    end
    if ((TMR_W < 1) || (TMR_W > 31)) begin : g_chk_tmr_w
        $error("drv_pwr_seq: TMR_W must be in 1..31");
    end
    else if (((STAGGER_CYC - 1) >= (32'd1 << TMR_W)) ||
             ((PWROK_TIMEOUT_CYC - 1) >= (32'd1 << TMR_W))) begin : g_chk_tmr_range
        $error("drv_pwr_seq: TMR_W too narrow for the configured cycle counts");
    end

    localparam logic [TMR_W-1:0] c_gap_last     = TMR_W'(STAGGER_CYC - 1);
    localparam logic [TMR_W-1:0] c_timeout_last = TMR_W'(PWROK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] c_tmr_one      = TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_WAIT_OK = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [NUM_DRV-1:0] r_pwren;
    logic [NUM_DRV-1:0] w_pwren_nxt;
    logic [NUM_DRV-1:0] r_fault;
    logic [NUM_DRV-1:0] w_fault_nxt;
    logic [4:0]         r_cur_idx;
    logic [4:0]         w_cur_nxt;

    logic [NUM_DRV-1:0] w_elig;
    logic               w_any_elig;
    logic [4:0]         w_sel;
    logic [NUM_DRV-1:0] w_pgloss;

    // Fixed-priority pick of the lowest eligible bay
    always_comb begin
        w_elig     = DRV_PRSNT & ~r_pwren & ~r_fault;
        w_any_elig = |w_elig;
        w_sel      = '0;
        for (int i = int'(NUM_DRV) - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel = 5'(i);
            end
        end
    end

    // The bay under sequencing is still ramping, so it is exempt from loss checks
    always_comb begin
        w_pgloss = r_pwren & ~DRV_PWROK & DRV_PRSNT;
        if (r_state == S_WAIT_OK) begin
            w_pgloss[r_cur_idx] = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_cur_nxt   = r_cur_idx;
        // Removal clears enable and fault; power-good loss trips the fault
        w_pwren_nxt = r_pwren & DRV_PRSNT & ~w_pgloss;
        w_fault_nxt = (r_fault | w_pgloss) & DRV_PRSNT;

        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (PWR_REQ) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                w_timer_nxt = '0;
                if (w_any_elig) begin
                    w_pwren_nxt[w_sel] = 1'b1;
                    w_cur_nxt          = w_sel;
                    w_state_nxt        = S_WAIT_OK;
                end
            end
            S_WAIT_OK: begin
                if (!DRV_PRSNT[r_cur_idx] || DRV_PWROK[r_cur_idx]) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_GAP;
                end
                else if (r_timer == c_timeout_last) begin
                    w_fault_nxt[r_cur_idx] = 1'b1;
                    w_pwren_nxt[r_cur_idx] = 1'b0;
                    w_timer_nxt            = '0;
                    w_state_nxt            = S_GAP;
                end
                else begin
                    w_timer_nxt = r_timer + c_tmr_one;
                end
            end
            S_GAP: begin
                if (r_timer == c_gap_last) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_SCAN;
                end
                else begin
                    w_timer_nxt = r_timer + c_tmr_one;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Dropping the request overrides sequencing; faults are kept
        if (!PWR_REQ) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_pwren_nxt = '0;
            w_fault_nxt = r_fault & DRV_PRSNT;
        end
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_pwren   <= '0;
            r_fault   <= '0;
            r_cur_idx <= '0;
        end
        else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pwren   <= w_pwren_nxt;
            r_fault   <= w_fault_nxt;
            r_cur_idx <= w_cur_nxt;
        end
    end

    assign DRV_PWREN = r_pwren;
    assign DRV_FAULT = r_fault;
    assign CUR_IDX   = r_cur_idx;
    assign SEQ_BUSY  = (r_state == S_WAIT_OK) || (r_state == S_GAP);
    assign SEQ_DONE  = (r_state == S_SCAN) && PWR_REQ && !w_any_elig;

endmodule
`default_nettype wire
